mem_access_unit: RTL and testbench

Load/store access unit between the datapath's ALU-output/B registers and the 64-bit data memory. It consumes the effective address and store operand produced by the execute stage and drives the data memory's address, data and write-enable ports. Loads return a size-extracted, sign- or zero-extended result to the memory-data register path. Byte, halfword and word stores use a read-modify-write sequence, so sub-doubleword stores never corrupt neighbouring bytes.

---
 rtl/mem_access_unit_if.sv | 27 ++
 rtl/mem_access_unit.sv | 139 +++++++++++++
 tb/tb_mem_access_unit.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/mem_access_unit_if.sv
// rtl/mem_access_unit_if.sv - request/response and data-memory signals of the load/store unit
interface mem_access_unit_if;
  logic        start;
  logic        is_store;
  logic [2:0]  funct3;
  logic [63:0] addr;
  logic [63:0] wdata;
  logic [63:0] mem_addr;
  logic [63:0] mem_wdata;
  logic        mem_wr;
  logic [63:0] mem_rdata;
  logic [63:0] load_data;
  logic        done;
  logic        busy;
  logic        misaligned;
  logic        bad_size;

  modport master (
    output start, is_store, funct3, addr, wdata, mem_rdata,
    input  mem_addr, mem_wdata, mem_wr, load_data, done, busy, misaligned, bad_size
  );

  modport slave (
    input  start, is_store, funct3, addr, wdata, mem_rdata,
    output mem_addr, mem_wdata, mem_wr, load_data, done, busy, misaligned, bad_size
  );
endinterface

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - load/store unit to 64-bit data memory with read-modify-write sub-doubleword stores
module mem_access_unit (
  input  logic             clk_i,
  input  logic             rst_i,
  mem_access_unit_if.slave bus
);
  typedef enum logic [2:0] {S_IDLE, S_RD, S_CAP, S_WR, S_FIN} state_e;

  state_e      state_q, state_d;
  logic        is_store_q, is_store_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [2:0]  off_q, off_d;
  logic [63:0] wdata_q, wdata_d;
  logic [63:0] mem_addr_q, mem_addr_d;
  logic [63:0] wbuf_q, wbuf_d;
  logic [63:0] load_q, load_d;
  logic        mis_q, mis_d;
  logic        bad_q, bad_d;

  logic        req_bad, req_mis;
  logic [5:0]  shamt;
  logic [63:0] size_mask, field, merged, extended;

  always_comb begin
    req_bad = (bus.funct3 == 3'b111) || (bus.is_store && bus.funct3[2]);
    case (bus.funct3[1:0])
      2'b01:   req_mis = bus.addr[0];
      2'b10:   req_mis = |bus.addr[1:0];
      2'b11:   req_mis = |bus.addr[2:0];
      default: req_mis = 1'b0;
    endcase
    if (req_bad) req_mis = 1'b0;
  end

  // Field extraction and store merge both work on the doubleword shifted by the byte offset.
  always_comb begin
    shamt = {off_q, 3'b000};
    case (funct3_q[1:0])
      2'b00:   size_mask = 64'h0000_0000_0000_00FF;
      2'b01:   size_mask = 64'h0000_0000_0000_FFFF;
      2'b10:   size_mask = 64'h0000_0000_FFFF_FFFF;
      default: size_mask = 64'hFFFF_FFFF_FFFF_FFFF;
    endcase
    field  = bus.mem_rdata >> shamt;
    merged = (bus.mem_rdata & ~(size_mask << shamt)) | ((wdata_q & size_mask) << shamt);
    case (funct3_q)
      3'b000:  extended = {{56{field[7]}}, field[7:0]};
      3'b001:  extended = {{48{field[15]}}, field[15:0]};
      3'b010:  extended = {{32{field[31]}}, field[31:0]};
      3'b100:  extended = {56'b0, field[7:0]};
      3'b101:  extended = {48'b0, field[15:0]};
      3'b110:  extended = {32'b0, field[31:0]};
      default: extended = field;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    is_store_d = is_store_q;
    funct3_d   = funct3_q;
    off_d      = off_q;
    wdata_d    = wdata_q;
    mem_addr_d = mem_addr_q;
    wbuf_d     = wbuf_q;
    load_d     = load_q;
    mis_d      = mis_q;
    bad_d      = bad_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          is_store_d = bus.is_store;
          funct3_d   = bus.funct3;
          off_d      = bus.addr[2:0];
          wdata_d    = bus.wdata;
          mem_addr_d = {bus.addr[63:3], 3'b000};
          wbuf_d     = bus.wdata;
          mis_d      = req_mis;
          bad_d      = req_bad;
          if (req_bad || req_mis) begin
            state_d = S_FIN;
          end else if (bus.is_store && (bus.funct3 == 3'b011)) begin
            state_d = S_WR;
          end else begin
            state_d = S_RD;
          end
        end
      end
      S_RD:  state_d = S_CAP;
      S_CAP: begin
        if (is_store_q) begin
          wbuf_d  = merged;
          state_d = S_WR;
        end else begin
          load_d  = extended;
          state_d = S_FIN;
        end
      end
      S_WR:    state_d = S_FIN;
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      is_store_q <= 1'b0;
      funct3_q   <= 3'b000;
      off_q      <= 3'b000;
      wdata_q    <= 64'b0;
      mem_addr_q <= 64'b0;
      wbuf_q     <= 64'b0;
      load_q     <= 64'b0;
      mis_q      <= 1'b0;
      bad_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      is_store_q <= is_store_d;
      funct3_q   <= funct3_d;
      off_q      <= off_d;
      wdata_q    <= wdata_d;
      mem_addr_q <= mem_addr_d;
      wbuf_q     <= wbuf_d;
      load_q     <= load_d;
      mis_q      <= mis_d;
      bad_q      <= bad_d;
    end
  end

  // Write enable decodes the state directly so reset removes it without a clock.
  assign bus.mem_wr     = (state_q == S_WR);
  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_wdata  = wbuf_q;
  assign bus.load_data  = load_q;
  assign bus.done       = (state_q == S_FIN);
  assign bus.busy       = (state_q != S_IDLE);
  assign bus.misaligned = mis_q;
  assign bus.bad_size   = bad_q;
endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - randomized and directed self-checking bench for mem_access_unit
module tb_mem_access_unit;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic sync_mem = 1'b1;
  int   checks = 0;
  int   errors = 0;

  logic [7:0]  ref_mem [0:255];
  logic [63:0] mem     [0:31];
  logic [63:0] last_load = 64'b0;
  logic [63:0] last_wr_data = 64'b0;

  mem_access_unit_if bus();

  mem_access_unit dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] ref_word(input int idx);
    logic [63:0] w;
    for (int b = 0; b < 8; b++) w[8*b +: 8] = ref_mem[idx*8 + b];
    return w;
  endfunction

  always @(posedge clk) begin
    if (sync_mem) begin
      for (int i = 0; i < 32; i++) mem[i] <= ref_word(i);
    end else if (bus.mem_wr) begin
      mem[bus.mem_addr[7:3]] <= bus.mem_wdata;
    end
    bus.mem_rdata <= mem[bus.mem_addr[7:3]];
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_mem(input string tag);
    int bad_words;
    bad_words = 0;
    for (int i = 0; i < 32; i++) if (mem[i] !== ref_word(i)) bad_words++;
    chk(tag, 64'(bad_words), 64'd0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_mem_addr"}, bus.mem_addr, 64'd0);
    chk({tag, "_mem_wdata"}, bus.mem_wdata, 64'd0);
    chk({tag, "_mem_wr"}, 64'(bus.mem_wr), 64'd0);
    chk({tag, "_load_data"}, bus.load_data, 64'd0);
    chk({tag, "_done"}, 64'(bus.done), 64'd0);
    chk({tag, "_busy"}, 64'(bus.busy), 64'd0);
    chk({tag, "_misaligned"}, 64'(bus.misaligned), 64'd0);
    chk({tag, "_bad_size"}, 64'(bus.bad_size), 64'd0);
  endtask

  // Issues one request, optionally keeps START high with garbage operands for `hold` busy cycles.
  task automatic run_op(input string tag, input logic st, input logic [2:0] f3,
                        input logic [63:0] a, input logic [63:0] wd, input int hold);
    int          sz, lat, exp_wr_cyc, done_cyc, wr_cnt, wr_cyc;
    logic        exp_bad, exp_mis, exp_err;
    logic [63:0] v, wr_addr;
    sz      = 1 << f3[1:0];
    exp_bad = (f3 == 3'b111) || (st && f3[2]);
    exp_mis = !exp_bad && ((a & 64'(sz - 1)) != 0);
    exp_err = exp_bad || exp_mis;
    if (exp_err)                 begin lat = 1; exp_wr_cyc = 0; end
    else if (!st)                begin lat = 3; exp_wr_cyc = 0; end
    else if (f3 == 3'b011)       begin lat = 2; exp_wr_cyc = 1; end
    else                         begin lat = 4; exp_wr_cyc = 3; end
    if (!exp_err && !st) begin
      v = 64'd0;
      for (int i = 0; i < sz; i++) v = v | (64'(ref_mem[a[7:0] + 8'(i)]) << (8*i));
      if (!f3[2] && sz < 8 && v[8*sz-1]) v = v | (~64'd0 << (8*sz));
      last_load = v;
    end

    @(negedge clk);
    bus.start = 1'b1; bus.is_store = st; bus.funct3 = f3; bus.addr = a; bus.wdata = wd;
    @(posedge clk);
    done_cyc = 0; wr_cnt = 0; wr_cyc = 0; wr_addr = 64'd0;
    for (int c = 1; c <= 8 && done_cyc == 0; c++) begin
      @(negedge clk);
      if (c <= hold) begin
        bus.start = 1'b1; bus.is_store = 1'b1; bus.funct3 = 3'b011;
        bus.addr = a ^ 64'h8; bus.wdata = {$urandom, $urandom};
      end else begin
        bus.start = 1'b0;
      end
      if (c == 1) chk({tag, "_busy"}, 64'(bus.busy), 64'd1);
      if (bus.mem_wr) begin
        wr_cnt++; wr_cyc = c; wr_addr = bus.mem_addr; last_wr_data = bus.mem_wdata;
      end
      if (bus.done) done_cyc = c;
    end
    bus.start = 1'b0;

    if (!exp_err && st) for (int i = 0; i < sz; i++) ref_mem[a[7:0] + 8'(i)] = wd[8*i +: 8];

    chk({tag, "_done_cycle"}, 64'(done_cyc), 64'(lat));
    chk({tag, "_wr_pulses"}, 64'(wr_cnt), (exp_wr_cyc != 0) ? 64'd1 : 64'd0);
    chk({tag, "_wr_cycle"}, 64'(wr_cyc), 64'(exp_wr_cyc));
    if (exp_wr_cyc != 0) begin
      chk({tag, "_wr_addr"}, wr_addr, {a[63:3], 3'b000});
      chk({tag, "_wr_data"}, last_wr_data, ref_word(int'(a[7:3])));
    end
    chk({tag, "_misaligned"}, 64'(bus.misaligned), 64'(exp_mis));
    chk({tag, "_bad_size"}, 64'(bus.bad_size), 64'(exp_bad));
    chk({tag, "_load_data"}, bus.load_data, last_load);
    @(posedge clk);
    chk_mem({tag, "_mem"});
  endtask

  initial begin
    logic [63:0] a;
    logic [2:0]  f3;
    logic        st;
    bus.start = 1'b0; bus.is_store = 1'b0; bus.funct3 = 3'b000;
    bus.addr = 64'd0; bus.wdata = 64'd0;
    for (int i = 0; i < 256; i++) ref_mem[i] = 8'($urandom);
    for (int i = 0; i < 8; i++) ref_mem[16 + i] = 8'(8'h11 * (i + 1));

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_all_zero("reset");
    sync_mem = 1'b0;
    rst = 1'b0;

    run_op("lb_13", 1'b0, 3'b000, 64'h13, 64'd0, 0);
    chk("lb_13_const", bus.load_data, 64'h0000_0000_0000_0044);
    run_op("lb_17", 1'b0, 3'b000, 64'h17, 64'd0, 0);
    chk("lb_17_const", bus.load_data, 64'hFFFF_FFFF_FFFF_FF88);
    run_op("lbu_17", 1'b0, 3'b100, 64'h17, 64'd0, 0);
    chk("lbu_17_const", bus.load_data, 64'h0000_0000_0000_0088);
    run_op("lw_14", 1'b0, 3'b010, 64'h14, 64'd0, 0);
    chk("lw_14_const", bus.load_data, 64'hFFFF_FFFF_8877_6655);
    run_op("lwu_14", 1'b0, 3'b110, 64'h14, 64'd0, 0);
    chk("lwu_14_const", bus.load_data, 64'h0000_0000_8877_6655);
    run_op("ld_10", 1'b0, 3'b011, 64'h10, 64'd0, 0);
    chk("ld_10_const", bus.load_data, 64'h8877_6655_4433_2211);
    run_op("sh_12", 1'b1, 3'b001, 64'h12, 64'hFFFF_EEEE_DDDD_ABCD, 0);
    chk("sh_12_const", last_wr_data, 64'h8877_6655_ABCD_2211);
    run_op("ld_10_merged", 1'b0, 3'b011, 64'h10, 64'd0, 0);
    chk("ld_10_merged_const", bus.load_data, 64'h8877_6655_ABCD_2211);
    run_op("sd_18", 1'b1, 3'b011, 64'h18, 64'h0123_4567_89AB_CDEF, 0);
    run_op("lw_12_mis", 1'b0, 3'b010, 64'h12, 64'd0, 0);
    run_op("st_bad", 1'b1, 3'b100, 64'h20, 64'h5555, 0);
    run_op("flags_clear", 1'b0, 3'b000, 64'h13, 64'd0, 0);
    run_op("ld_f3_111", 1'b0, 3'b111, 64'h08, 64'd0, 0);
    run_op("busy_ignore", 1'b0, 3'b000, 64'h13, 64'd0, 2);
    run_op("busy_ignore_st", 1'b1, 3'b000, 64'h31, 64'h77, 3);

    for (int n = 0; n < 150; n++) begin
      st = 1'($urandom);
      f3 = 3'($urandom);
      a  = 64'($urandom_range(0, 255));
      if ($urandom_range(0, 3) != 0) a = a & ~64'((1 << f3[1:0]) - 1);
      run_op("rand", st, f3, a, {$urandom, $urandom}, 0);
    end

    // Reset asserted between clock edges while the write strobe is up.
    @(negedge clk);
    bus.start = 1'b1; bus.is_store = 1'b1; bus.funct3 = 3'b001;
    bus.addr = 64'h22; bus.wdata = 64'h0000_0000_0000_BEEF;
    @(posedge clk);
    @(negedge clk); bus.start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_wr_before", 64'(bus.mem_wr), 64'd1);
    rst = 1'b1;
    #1;
    chk("rst_wr_async", 64'(bus.mem_wr), 64'd0);
    @(posedge clk);
    @(negedge clk);
    chk_all_zero("rst_mid");
    rst = 1'b0;
    last_load = 64'd0;
    @(posedge clk);
    chk_mem("rst_mem_unchanged");
    run_op("post_rst_ld", 1'b0, 3'b011, 64'h20, 64'd0, 0);
    run_op("post_rst_lh", 1'b0, 3'b001, 64'h26, 64'd0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
